// File: rtl/pkt_fifo.sv
// Single-clock packet FIFO with a registered read port, occupancy flags and
// sticky overflow/underflow error flags. Sits between rd_ctrl and its consumer.
module pkt_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;

    logic rd_acc;
    logic wr_acc;
    logic wr_drop;
    logic rd_rej;

    // Flags depend only on the registered count, so rd_ctrl never sees a
    // combinational loop through almost_full.
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(AF_THRESH));

    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write when it is also being read. No bypass: empty always rejects reads.
    assign rd_acc  = rd_en && !empty;
    assign wr_acc  = wr_en && (!full || rd_acc);
    assign wr_drop = wr_en && full && !rd_acc;
    assign rd_rej  = rd_en && empty;

    // Storage is deliberately not reset; pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_acc) begin
                wp <= wp + PTR_W'(1);
            end
            if (rd_acc) begin
                rp <= rp + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered read port: data lands one cycle after the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rp];
            end
        end
    end

    // A fresh error in the same cycle as clear_err takes precedence.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (rd_rej) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
